conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_W, 28: input feature-map width.
- IMG_H, 28: input feature-map height.
- K, 5: square kernel size.
- NUM_FILT, 8: number of filters.
- RD_LAT, 1: read latency of the image RAM and kernel ROM, in cycles, range 1..3.
- IMG_AW, 10: image address width.
- KERN_AW, 8: kernel ROM address width.
- OUT_AW, 13: output RAM address width.

REQ-002 Derived values: OUT_W = IMG_W-K+1; OUT_H = IMG_H-K+1; window count W = NUM_FILT*OUT_H*OUT_W; window length L = K*K+RD_LAT+2.

REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: request a full layer pass.
- hold, in, 1: freeze address issue.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle completion pulse.
- img_addr, out, IMG_AW: image RAM read address.
- img_re, out, 1: image RAM read enable.
- kern_addr, out, KERN_AW: kernel ROM read address.
- kern_re, out, 1: kernel ROM read enable.
- mac_clr, out, 1: clear the MAC accumulator.
- mac_en, out, 1: the MAC accumulates the returned data this cycle.
- out_addr, out, OUT_AW: output RAM write address.
- out_we, out, 1: output RAM write enable.

REQ-004 The clock is clk; reset is reset, synchronous, active-high.

Function
REQ-005 The FSM SHALL have the states IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE.
REQ-006 Loop nesting, outermost first: filter f, output row r, output column c, kernel row kr, kernel column kc; all counters start at 0.
REQ-007 IDLE -> CLEAR SHALL occur on the clock edge where start=1; start is ignored in every other state.
REQ-008 CLEAR SHALL last 1 cycle, assert mac_clr=1, and set kr=kc=0.
REQ-009 ACCUM SHALL issue one read per cycle with img_re=kern_re=1 while hold=0.
- img_addr = (r+kr)*IMG_W + (c+kc).
- kern_addr = f*K*K + kr*K + kc.
- kc advances first and wraps at K-1 into kr.
REQ-010 While in ACCUM with hold=1: img_re=kern_re=0 and kr, kc, img_addr, kern_addr hold their values.
REQ-011 ACCUM -> DRAIN SHALL occur on the cycle that issues kr=K-1, kc=K-1.
REQ-012 mac_en SHALL equal the issue strobe (img_re) delayed by exactly RD_LAT cycles via a shift register; hold does not affect reads already in flight.
REQ-013 DRAIN SHALL last exactly RD_LAT cycles and then go to WRITE, so the last mac_en precedes out_we by 1 cycle.
REQ-014 WRITE SHALL last 1 cycle with out_we=1 and out_addr = f*OUT_H*OUT_W + r*OUT_W + c.
REQ-015 After WRITE, c, r, f SHALL advance (c fastest).
- Next state is CLEAR unless the window just written was f=NUM_FILT-1, r=OUT_H-1, c=OUT_W-1.
- In that case the next state is DONE.
REQ-016 DONE SHALL last 1 cycle with done=1, clear all counters, and go to IDLE.
REQ-017 Exactly one of mac_clr, img_re, out_we, done is high in any cycle, or none of them.
REQ-018 Timing with hold held 0, where cycle 0 is the start-accept cycle:
- first mac_clr in cycle 1;
- out_we in cycle n*L for window n = 1..W;
- done in cycle W*L+1;
- busy low again in cycle W*L+2.
REQ-019 Each hold cycle in ACCUM SHALL extend all later events by exactly 1 cycle; hold has no effect in other states.
REQ-020 Address arithmetic SHALL be computed at full width and truncated to the port width; parameter sets that overflow are illegal and are not checked.

Reset
REQ-021 reset=1 SHALL, on the next edge, force IDLE from any state:
- all counters 0;
- the mac_en pipeline cleared;
- all outputs 0, including addresses.
REQ-022 Reset SHALL take priority over start and hold.
REQ-023 A reset mid-layer SHALL abandon the pass with no out_we or done afterward; a new start restarts at f=r=c=0.

Verification
REQ-024 Full pass, IMG_W=IMG_H=4, K=3, NUM_FILT=2, RD_LAT=1, hold=0; start pulsed once -> L=12, W=8; out_we at cycles 12, 24, ..., 96 with out_addr 0..7 in order; done at cycle 97 only; busy low at cycle 98.
REQ-025 Addresses for the same parameters -> window 0 img_addr sequence 0,1,2,4,5,6,8,9,10 and kern_addr 0..8; window 4 (f=1, r=0, c=0) kern_addr 9..17.
REQ-026 hold=1 for 3 cycles during the first ACCUM -> img_addr frozen for those 3 cycles; mac_en count per window still 9; done at cycle 100.
REQ-027 RD_LAT=3 -> L=14; the last mac_en of each window occurs 1 cycle before out_we; done at cycle 113.
REQ-028 reset asserted in cycle 30 -> IDLE at cycle 31 with all outputs 0; no further out_we; a new start reproduces the REQ-024 trace from out_addr 0.
REQ-029 start held high continuously -> no effect while busy; a second pass begins in the cycle after DONE returns the FSM to IDLE (the start-accept cycle is cycle 98).

Source files
------------

// File: rtl/conv_sequencer.sv
// Address and control sequencer for a direct-form convolution layer: walks filters,
// output pixels and kernel taps, and drives image/kernel reads, MAC control and output writes.
module conv_sequencer #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 5,
  parameter int NUM_FILT = 8,
  parameter int RD_LAT   = 1,
  parameter int IMG_AW   = 10,
  parameter int KERN_AW  = 8,
  parameter int OUT_AW   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [IMG_AW-1:0]  img_addr,
  output logic               img_re,
  output logic [KERN_AW-1:0] kern_addr,
  output logic               kern_re,
  output logic               mac_clr,
  output logic               mac_en,
  output logic [OUT_AW-1:0]  out_addr,
  output logic               out_we
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE} state_t;

  state_t            state;
  logic [31:0]       f, r, c, kr, kc;
  logic [31:0]       drain_cnt;
  logic [RD_LAT-1:0] mac_pipe;
  logic              issue;

  // hold gates the read strobe in the same cycle; reads already issued keep flowing
  assign issue = (state == ACCUM) && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      f         <= '0;
      r         <= '0;
      c         <= '0;
      kr        <= '0;
      kc        <= '0;
      drain_cnt <= '0;
      mac_pipe  <= '0;
    end else begin
      mac_pipe <= RD_LAT'({mac_pipe, issue});
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          kr    <= '0;
          kc    <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (!hold) begin
            if (kc == K - 1) begin
              kc <= '0;
              if (kr == K - 1) begin
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                kr <= kr + 1;
              end
            end else begin
              kc <= kc + 1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == RD_LAT - 1) state <= WRITE;
          else drain_cnt <= drain_cnt + 1;
        end
        WRITE: begin
          state <= CLEAR;
          if (c == OUT_W - 1) begin
            c <= '0;
            if (r == OUT_H - 1) begin
              r <= '0;
              if (f == NUM_FILT - 1) begin
                f     <= '0;
                state <= DONE;
              end else begin
                f <= f + 1;
              end
            end else begin
              r <= r + 1;
            end
          end else begin
            c <= c + 1;
          end
        end
        DONE: begin
          f     <= '0;
          r     <= '0;
          c     <= '0;
          kr    <= '0;
          kc    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mac_clr = (state == CLEAR);
  assign out_we  = (state == WRITE);
  assign img_re  = issue;
  assign kern_re = issue;
  assign mac_en  = mac_pipe[RD_LAT-1];

  // addresses read as zero outside the states that use them
  assign img_addr  = (state == ACCUM) ? IMG_AW'((r + kr) * IMG_W + c + kc) : '0;
  assign kern_addr = (state == ACCUM) ? KERN_AW'(f * (K * K) + kr * K + kc) : '0;
  assign out_addr  = (state == WRITE) ? OUT_AW'(f * (OUT_H * OUT_W) + r * OUT_W + c) : '0;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a 4x4 image, 3x3 kernel, 2 filters, with
// one instance at read latency 1 and one at read latency 3.
module tb_conv_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int K     = 3;
  localparam int NF    = 2;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int WIN   = NF * OUT_H * OUT_W;
  localparam int L_A   = K * K + 1 + 2;
  localparam int L_B   = K * K + 3 + 2;

  typedef struct {int addr; int cyc;} wr_t;
  typedef struct {int img; int kern;} rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  logic reset, start, hold, start_b, hold_b;
  logic busy, done, img_re, kern_re, mac_clr, mac_en, out_we;
  logic [9:0] img_addr;
  logic [7:0] kern_addr;
  logic [12:0] out_addr;
  logic busy_b, done_b, img_re_b, kern_re_b, mac_clr_b, mac_en_b, out_we_b;
  logic [9:0] img_addr_b;
  logic [7:0] kern_addr_b;
  logic [12:0] out_addr_b;

  conv_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_FILT(NF), .RD_LAT(1),
                   .IMG_AW(10), .KERN_AW(8), .OUT_AW(13)) dut_a (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .busy(busy), .done(done),
    .img_addr(img_addr), .img_re(img_re), .kern_addr(kern_addr), .kern_re(kern_re),
    .mac_clr(mac_clr), .mac_en(mac_en), .out_addr(out_addr), .out_we(out_we));

  conv_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_FILT(NF), .RD_LAT(3),
                   .IMG_AW(10), .KERN_AW(8), .OUT_AW(13)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .hold(hold_b), .busy(busy_b), .done(done_b),
    .img_addr(img_addr_b), .img_re(img_re_b), .kern_addr(kern_addr_b), .kern_re(kern_re_b),
    .mac_clr(mac_clr_b), .mac_en(mac_en_b), .out_addr(out_addr_b), .out_we(out_we_b));

  wr_t wq_a[$], wq_b[$];
  rd_t iq_a[$], iq_b[$];
  int  dq_a[$], dq_b[$];
  int  tests = 0, errors = 0;
  int  mac_cnt_a = 0, mac_cnt_b = 0, last_mac_a = 0, last_mac_b = 0;
  wr_t ew_a, ew_b;
  rd_t er_a, er_b;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // expected reads, writes and done pulse of one full pass, cycles relative to the accept cycle
  task automatic pushPass(input bit to_b, input int base, input int extra);
    int n;
    rd_t rd;
    n = 0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < OUT_H; r++)
        for (int c = 0; c < OUT_W; c++) begin
          n++;
          for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++) begin
              rd.img  = (r + kr) * IMG_W + c + kc;
              rd.kern = f * K * K + kr * K + kc;
              if (to_b) iq_b.push_back(rd); else iq_a.push_back(rd);
            end
          if (to_b) wq_b.push_back('{n - 1, base + n * L_B});
          else      wq_a.push_back('{n - 1, base + n * L_A + extra});
        end
    if (to_b) dq_b.push_back(base + WIN * L_B + 1);
    else      dq_a.push_back(base + WIN * L_A + 1 + extra);
  endtask

  task automatic waitUntil(input int target);
    while (pc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_flags"}, 32'({busy, done, img_re, kern_re, mac_clr, mac_en, out_we}), 0);
    checkOutput({tag, "_img"}, 32'(img_addr), 0);
    checkOutput({tag, "_kern"}, 32'(kern_addr), 0);
    checkOutput({tag, "_out"}, 32'(out_addr), 0);
  endtask

  // one pulsed start on instance A, optionally with three hold cycles in the first window
  task automatic applyStimulus(input bit do_hold);
    int base, extra;
    base  = pc;
    extra = do_hold ? 3 : 0;
    pushPass(1'b0, base, extra);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (do_hold) begin
      waitUntil(base + 4);
      hold = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checkOutput("hold_re", 32'({img_re, kern_re}), 0);
        checkOutput("hold_img", 32'(img_addr), iq_a[0].img);
        checkOutput("hold_kern", 32'(kern_addr), iq_a[0].kern);
        @(posedge clk); #1;
      end
      hold = 1'b0;
    end
    waitUntil(base + WIN * L_A + 1 + extra);
    @(negedge clk);
    checkOutput("busy_in_done", 32'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy_low", 32'(busy), 0);
    checkOutput("pend_writes", wq_a.size(), 0);
    checkOutput("pend_reads", iq_a.size(), 0);
    checkOutput("pend_done", dq_a.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mac_clr || img_re || out_we || done)
      checkOutput("excl_a", 32'($countones({mac_clr, img_re, out_we, done})), 1);
    if (mac_clr) mac_cnt_a = 0;
    if (mac_en) begin
      mac_cnt_a++;
      last_mac_a = pc;
    end
    if (img_re) begin
      if (iq_a.size() == 0) checkOutput("unexp_rd_a", 32'(img_re), 0);
      else begin
        er_a = iq_a.pop_front();
        checkOutput("img_addr_a", 32'(img_addr), er_a.img);
        checkOutput("kern_addr_a", 32'(kern_addr), er_a.kern);
        checkOutput("kern_re_a", 32'(kern_re), 1);
      end
    end
    if (out_we) begin
      if (wq_a.size() == 0) checkOutput("unexp_we_a", 32'(out_we), 0);
      else begin
        ew_a = wq_a.pop_front();
        checkOutput("out_addr_a", 32'(out_addr), ew_a.addr);
        checkOutput("we_cycle_a", pc, ew_a.cyc);
        checkOutput("mac_count_a", mac_cnt_a, K * K);
        checkOutput("mac_last_a", last_mac_a, pc - 1);
      end
    end
    if (done) begin
      if (dq_a.size() == 0) checkOutput("unexp_done_a", 32'(done), 0);
      else checkOutput("done_cycle_a", pc, dq_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mac_clr_b || img_re_b || out_we_b || done_b)
      checkOutput("excl_b", 32'($countones({mac_clr_b, img_re_b, out_we_b, done_b})), 1);
    if (mac_clr_b) mac_cnt_b = 0;
    if (mac_en_b) begin
      mac_cnt_b++;
      last_mac_b = pc;
    end
    if (img_re_b) begin
      if (iq_b.size() == 0) checkOutput("unexp_rd_b", 32'(img_re_b), 0);
      else begin
        er_b = iq_b.pop_front();
        checkOutput("img_addr_b", 32'(img_addr_b), er_b.img);
        checkOutput("kern_addr_b", 32'(kern_addr_b), er_b.kern);
        checkOutput("kern_re_b", 32'(kern_re_b), 1);
      end
    end
    if (out_we_b) begin
      if (wq_b.size() == 0) checkOutput("unexp_we_b", 32'(out_we_b), 0);
      else begin
        ew_b = wq_b.pop_front();
        checkOutput("out_addr_b", 32'(out_addr_b), ew_b.addr);
        checkOutput("we_cycle_b", pc, ew_b.cyc);
        checkOutput("mac_count_b", mac_cnt_b, K * K);
        checkOutput("mac_last_b", last_mac_b, pc - 1);
      end
    end
    if (done_b) begin
      if (dq_b.size() == 0) checkOutput("unexp_done_b", 32'(done_b), 0);
      else checkOutput("done_cycle_b", pc, dq_b.pop_front());
    end
  end

  initial begin
    int base;
    reset   = 1'b1;
    start   = 1'b0;
    hold    = 1'b0;
    start_b = 1'b0;
    hold_b  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_b", 32'({busy_b, img_re_b, mac_en_b, out_we_b, done_b, img_addr_b}), 0);
    @(posedge clk); #1;
    checkOutput("rst_prio", 32'(busy), 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(1'b0);

    // read latency 3 on the second instance
    base = pc;
    pushPass(1'b1, base, 0);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    waitUntil(base + WIN * L_B + 2);
    @(negedge clk);
    checkOutput("busy_low_b", 32'(busy_b), 0);
    checkOutput("pend_writes_b", wq_b.size(), 0);
    checkOutput("pend_done_b", dq_b.size(), 0);
    @(posedge clk); #1;

    applyStimulus(1'b1);

    // reset in the middle of a pass abandons it
    base = pc;
    pushPass(1'b0, base, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitUntil(base + 30);
    reset = 1'b1;
    @(posedge clk); #1;
    iq_a.delete();
    wq_a.delete();
    dq_a.delete();
    @(negedge clk);
    checkIdle("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(1'b0);

    // start held high: the second pass is accepted in the cycle busy falls
    base = pc;
    pushPass(1'b0, base, 0);
    pushPass(1'b0, base + WIN * L_A + 2, 0);
    start = 1'b1;
    waitUntil(base + WIN * L_A + 2);
    @(negedge clk);
    checkOutput("busy_gap", 32'(busy), 0);
    @(posedge clk); #1;
    checkOutput("restart", 32'(mac_clr), 1);
    waitUntil(base + WIN * L_A + 4);
    start = 1'b0;
    waitUntil(base + 2 * (WIN * L_A + 2));
    @(negedge clk);
    checkOutput("busy_low2", 32'(busy), 0);
    checkOutput("pend_writes2", wq_a.size(), 0);
    checkOutput("pend_done2", dq_a.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_third", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
